tlb_sv32_dm512: RTL and testbench

//  Direct-mapped 512-entry Sv32 TLB controller that owns one sram_sp_gf180_512x56 instance.

---
 rtl/tlb_sv32_dm512.sv | 184 ++++++++++++++++++
 tb/tb_tlb_sv32_dm512.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_sv32_dm512.sv
// Direct-mapped 512-entry Sv32 TLB controller.
// Drives one external single-port 512x56 SRAM macro (registered read, one-cycle latency).
// It serves translate lookups, writes PTW fills, and runs invalidation sweeps.
// A sweep runs after reset and on sfence.vma, because the macro powers up with undefined contents.
// Superpages are stored splintered as 4 KiB entries.
// Entry layout: [55:51] reserved=0, [50] V, [49:41] ASID, [40:30] tag=VPN[19:9], [29:8] PPN, [7:0] flags.
module tlb_sv32_dm512 #(
    parameter int ASID_W     = 9,     // entry layout assumes 9
    parameter bit INIT_FLUSH = 1'b1   // 0 skips the power-on sweep (simulation only)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lookup_valid,
    output logic              lookup_ready,
    input  logic [19:0]       lookup_vpn,
    input  logic [ASID_W-1:0] lookup_asid,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [21:0]       resp_ppn,
    output logic [7:0]        resp_flags,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [19:0]       fill_vpn,
    input  logic [ASID_W-1:0] fill_asid,
    input  logic [21:0]       fill_ppn,
    input  logic [7:0]        fill_flags,
    input  logic              flush_req,
    output logic              busy,
    output logic              sram_we,
    output logic [8:0]        sram_addr,
    output logic [55:0]       sram_din,
    input  logic [55:0]       sram_dout
);

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CMP   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [8:0]          r_cnt;
    logic                r_flush_pend;
    logic [10:0]         r_tag;
    logic [ASID_W-1:0]   r_asid;
    logic                r_resp_valid;
    logic                r_resp_hit;
    logic [21:0]         r_resp_ppn;
    logic [7:0]          r_resp_flags;

    logic                w_idle;
    logic                w_fill_ready;
    logic                w_lookup_ready;
    logic                w_fill_fire;
    logic                w_lookup_fire;
    logic                w_hit;
    logic                w_we;
    logic [8:0]          w_addr;
    logic [55:0]         w_din;
    logic                w_unused_rsvd;

    // Read-side views of the stored entry.
    logic                w_e_v;
    logic [ASID_W-1:0]   w_e_asid;
    logic [10:0]         w_e_tag;
    logic [21:0]         w_e_ppn;
    logic [7:0]          w_e_flags;

    assign w_e_v         = sram_dout[50];
    assign w_e_asid      = sram_dout[49:41];
    assign w_e_tag       = sram_dout[40:30];
    assign w_e_ppn       = sram_dout[29:8];
    assign w_e_flags     = sram_dout[7:0];
    assign w_unused_rsvd = &{1'b0, sram_dout[55:51]};

    // Pending or incoming flush blocks everything; a fill in the same cycle blocks lookups.
    assign w_idle         = (r_state == ST_IDLE);
    assign w_fill_ready   = w_idle & ~flush_req & ~r_flush_pend;
    assign w_lookup_ready = w_idle & ~flush_req & ~r_flush_pend & ~fill_valid;
    assign w_fill_fire    = fill_valid & w_fill_ready;
    assign w_lookup_fire  = lookup_valid & w_lookup_ready;

    // Global pages (flags bit 5) match regardless of ASID.
    assign w_hit = w_e_v & (w_e_tag == r_tag) & (w_e_flags[5] | (w_e_asid == r_asid));

    assign lookup_ready = w_lookup_ready;
    assign fill_ready   = w_fill_ready;
    assign busy         = ~w_idle;
    assign resp_valid   = r_resp_valid;
    assign resp_hit     = r_resp_hit;
    assign resp_ppn     = r_resp_ppn;
    assign resp_flags   = r_resp_flags;

    // SRAM port: sweep writes zeros, fill writes the packed entry, otherwise present the lookup row.
    always_comb begin
        w_we   = 1'b0;
        w_addr = 9'd0;
        w_din  = 56'd0;
        case (r_state)
            ST_SWEEP: begin
                w_we   = 1'b1;
                w_addr = r_cnt;
            end
            ST_IDLE: begin
                if (w_fill_fire) begin
                    w_we   = 1'b1;
                    w_addr = fill_vpn[8:0];
                    w_din  = {5'd0, 1'b1, fill_asid, fill_vpn[19:9], fill_ppn, fill_flags};
                end else begin
                    w_addr = lookup_vpn[8:0];
                end
            end
            default: begin
                w_we   = 1'b0;
                w_addr = 9'd0;
            end
        endcase
    end

    // The state register sits in SWEEP while reset is held, so qualify the write strobe with reset.
    assign sram_we   = w_we & resetn;
    assign sram_addr = w_addr;
    assign sram_din  = w_din;

    // Controller state, sweep counter, request capture and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= INIT_FLUSH ? ST_SWEEP : ST_IDLE;
            r_cnt        <= 9'd0;
            r_flush_pend <= 1'b0;
            r_tag        <= 11'd0;
            r_asid       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_ppn   <= 22'd0;
            r_resp_flags <= 8'd0;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    r_resp_valid <= 1'b0;
                    if (flush_req) begin
                        r_cnt <= 9'd0;
                    end else if (r_cnt == 9'd511) begin
                        r_cnt   <= 9'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (flush_req | r_flush_pend) begin
                        r_state      <= ST_SWEEP;
                        r_cnt        <= 9'd0;
                        r_flush_pend <= 1'b0;
                    end else if (w_lookup_fire) begin
                        r_tag   <= lookup_vpn[19:9];
                        r_asid  <= lookup_asid;
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= w_hit;
                    r_resp_ppn   <= w_hit ? w_e_ppn : 22'd0;
                    r_resp_flags <= w_hit ? w_e_flags : 8'd0;
                    r_state      <= ST_RESP;
                    if (flush_req) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                    if (flush_req) begin
                        r_flush_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_sv32_dm512.sv
// Directed testbench for tlb_sv32_dm512 with a behavioural 512x56 registered-read SRAM.
module tb_tlb_sv32_dm512;

    logic        clk;
    logic        resetn;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [19:0] lookup_vpn;
    logic [8:0]  lookup_asid;
    logic        resp_valid;
    logic        resp_hit;
    logic [21:0] resp_ppn;
    logic [7:0]  resp_flags;
    logic        fill_valid;
    logic        fill_ready;
    logic [19:0] fill_vpn;
    logic [8:0]  fill_asid;
    logic [21:0] fill_ppn;
    logic [7:0]  fill_flags;
    logic        flush_req;
    logic        busy;
    logic        sram_we;
    logic [8:0]  sram_addr;
    logic [55:0] sram_din;
    logic [55:0] sram_dout;

    logic [55:0] mem [0:511];

    int checks;
    int failures;

    tlb_sv32_dm512 #(.ASID_W(9), .INIT_FLUSH(1'b1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_vpn   (lookup_vpn),
        .lookup_asid  (lookup_asid),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_ppn     (resp_ppn),
        .resp_flags   (resp_flags),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_vpn     (fill_vpn),
        .fill_asid    (fill_asid),
        .fill_ppn     (fill_ppn),
        .fill_flags   (fill_flags),
        .flush_req    (flush_req),
        .busy         (busy),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: write-through of we, registered read of the addressed row.
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at negedge+1 while a sweep is running; counts zero-writes at rows 0..511.
    task automatic wait_sweep(input string tag);
        int n;
        int err;
        n   = 0;
        err = 0;
        while (busy && n < 2000) begin
            if (!(sram_we === 1'b1 && sram_addr === n[8:0] && sram_din === 56'd0)) err++;
            n++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_sweep_cycles"}, 64'(n), 64'd512);
        check_eq({tag, "_sweep_bad_writes"}, 64'(err), 64'd0);
        check_eq({tag, "_ready_after_sweep"}, {63'd0, lookup_ready}, 64'd1);
        $display("sweep %s: %0d cycles, %0d bad writes", tag, n, err);
    endtask

    // Entered at negedge+1 in IDLE; one accepted fill cycle.
    task automatic do_fill(input string tag, input logic [19:0] vpn, input logic [8:0] asid,
                           input logic [21:0] ppn, input logic [7:0] flags);
        logic [55:0] exp_entry;
        exp_entry    = {5'd0, 1'b1, asid, vpn[19:9], ppn, flags};
        fill_valid   = 1'b1;
        fill_vpn     = vpn;
        fill_asid    = asid;
        fill_ppn     = ppn;
        fill_flags   = flags;
        lookup_valid = 1'b1;
        #1;
        check_eq({tag, "_fill_ready"}, {63'd0, fill_ready}, 64'd1);
        check_eq({tag, "_lookup_blocked"}, {63'd0, lookup_ready}, 64'd0);
        check_eq({tag, "_we"}, {63'd0, sram_we}, 64'd1);
        check_eq({tag, "_addr"}, {55'd0, sram_addr}, {55'd0, vpn[8:0]});
        check_eq({tag, "_din"}, {8'd0, sram_din}, {8'd0, exp_entry});
        $display("fill %s: vpn=%05h asid=%0d ppn=%06h flags=%02h", tag, vpn, asid, ppn, flags);
        @(negedge clk);
        fill_valid   = 1'b0;
        lookup_valid = 1'b0;
        #1;
    endtask

    // Entered at negedge+1 in IDLE; accept, then expect the response two cycles later.
    task automatic do_lookup(input string tag, input logic [19:0] vpn, input logic [8:0] asid,
                             input logic hit, input logic [21:0] ppn, input logic [7:0] flags);
        lookup_valid = 1'b1;
        lookup_vpn   = vpn;
        lookup_asid  = asid;
        #1;
        check_eq({tag, "_ready"}, {63'd0, lookup_ready}, 64'd1);
        check_eq({tag, "_no_we"}, {63'd0, sram_we}, 64'd0);
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        check_eq({tag, "_no_early_resp"}, {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        #1;
        check_eq({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
        check_eq({tag, "_hit"}, {63'd0, resp_hit}, {63'd0, hit});
        check_eq({tag, "_ppn"}, {42'd0, resp_ppn}, {42'd0, ppn});
        check_eq({tag, "_flags"}, {56'd0, resp_flags}, {56'd0, flags});
        $display("lookup %s: vpn=%05h asid=%0d hit=%0d ppn=%06h flags=%02h",
                 tag, vpn, asid, resp_hit, resp_ppn, resp_flags);
        @(negedge clk);
        #1;
        check_eq({tag, "_pulse_end"}, {63'd0, resp_valid}, 64'd0);
        check_eq({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        resetn       = 1'b0;
        lookup_valid = 1'b0;
        lookup_vpn   = 20'd0;
        lookup_asid  = 9'd0;
        fill_valid   = 1'b0;
        fill_vpn     = 20'd0;
        fill_asid    = 9'd0;
        fill_ppn     = 22'd0;
        fill_flags   = 8'd0;
        flush_req    = 1'b0;
        // Garbage power-up contents with V set everywhere.
        for (int i = 0; i < 512; i++) mem[i] = {56{1'b1}};

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
        check_eq("rst_resp_ppn", {42'd0, resp_ppn}, 64'd0);
        check_eq("rst_resp_flags", {56'd0, resp_flags}, 64'd0);
        check_eq("rst_sram_we", {63'd0, sram_we}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd1);

        // 1. Power-on sweep
        @(negedge clk);
        resetn = 1'b1;
        #1;
        wait_sweep("t1");

        // 2. Fill then hit
        do_fill("t2", 20'h12345, 9'd3, 22'h2ABCD, 8'hCF);
        do_lookup("t2_hit", 20'h12345, 9'd3, 1'b1, 22'h2ABCD, 8'hCF);

        // 3. ASID mismatch misses; global refill hits under any ASID
        do_lookup("t3_miss", 20'h12345, 9'd4, 1'b0, 22'd0, 8'd0);
        do_fill("t3", 20'h12345, 9'd3, 22'h2ABCD, 8'hEF);
        do_lookup("t3_ghit", 20'h12345, 9'd4, 1'b1, 22'h2ABCD, 8'hEF);

        // 4. Alias at the same index replaces the entry
        do_fill("t4", 20'h00345, 9'd3, 22'h01111, 8'hCF);
        do_lookup("t4_miss", 20'h12345, 9'd3, 1'b0, 22'd0, 8'd0);
        do_lookup("t4_hit", 20'h00345, 9'd3, 1'b1, 22'h01111, 8'hCF);

        // 5. Flush during CMP: response completes with old data, then sweep
        lookup_valid = 1'b1;
        lookup_vpn   = 20'h00345;
        lookup_asid  = 9'd3;
        #1;
        check_eq("t5_ready", {63'd0, lookup_ready}, 64'd1);
        @(negedge clk);
        lookup_valid = 1'b0;
        flush_req    = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        check_eq("t5_resp_valid", {63'd0, resp_valid}, 64'd1);
        check_eq("t5_hit", {63'd0, resp_hit}, 64'd1);
        check_eq("t5_ppn", {42'd0, resp_ppn}, {42'd0, 22'h01111});
        $display("lookup t5_flush: vpn=00345 hit=%0d ppn=%06h", resp_hit, resp_ppn);
        @(negedge clk);
        #1;
        check_eq("t5_pend_idle", {63'd0, busy}, 64'd0);
        check_eq("t5_pend_lookup_blocked", {63'd0, lookup_ready}, 64'd0);
        check_eq("t5_pend_fill_blocked", {63'd0, fill_ready}, 64'd0);
        @(negedge clk);
        #1;
        wait_sweep("t5");
        do_lookup("t5_after", 20'h00345, 9'd3, 1'b0, 22'd0, 8'd0);

        // 6. Flush beats fill and lookup in the same cycle
        do_fill("t6_pre", 20'h0ABCD, 9'd7, 22'h3FFFF, 8'h0F);
        flush_req    = 1'b1;
        fill_valid   = 1'b1;
        fill_vpn     = 20'h12345;
        fill_asid    = 9'd3;
        fill_ppn     = 22'h15555;
        fill_flags   = 8'hCF;
        lookup_valid = 1'b1;
        lookup_vpn   = 20'h0ABCD;
        lookup_asid  = 9'd7;
        #1;
        check_eq("t6_fill_ready", {63'd0, fill_ready}, 64'd0);
        check_eq("t6_lookup_ready", {63'd0, lookup_ready}, 64'd0);
        check_eq("t6_no_we", {63'd0, sram_we}, 64'd0);
        $display("flush t6: flush+fill+lookup same cycle");
        @(negedge clk);
        flush_req    = 1'b0;
        fill_valid   = 1'b0;
        lookup_valid = 1'b0;
        #1;
        check_eq("t6_busy", {63'd0, busy}, 64'd1);
        repeat (100) @(negedge clk);
        #1;
        check_eq("t6_mid_addr", {55'd0, sram_addr}, 64'd100);
        // Reset in the middle of the sweep restarts it at row 0
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_we", {63'd0, sram_we}, 64'd0);
        check_eq("t6_rst_resp", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_eq("t6_restart_addr", {55'd0, sram_addr}, 64'd0);
        wait_sweep("t6");
        do_lookup("t6_pre_gone", 20'h0ABCD, 9'd7, 1'b0, 22'd0, 8'd0);
        do_lookup("t6_fill_dropped", 20'h12345, 9'd3, 1'b0, 22'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
